// File: rtl/uart_link_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_link_arbiter_if
// Groups all handshake and bus signals between the two link requesters
// (instruction fetcher F, load/store unit M), the UART and the arbiter.
//   slave  : the arbiter's view. It receives requests, releases, transmit
//            controls and UART strobes. It drives the muxed UART controls,
//            grants, gated strobes, stop_f and timeout.
//   master : the environment's view (requesters plus UART), the mirror image.
// Signals:
//   req_f/req_m          level requests
//   done_f/done_m        one-cycle release pulses
//   tx_start_f/m (low)   requester transmit starts
//   tx_data_f/m [7:0]    requester transmit bytes
//   uart_tx_done         UART byte-complete strobe
//   uart_rx_do           UART byte-valid strobe
//   uart_tx_start (low)  muxed transmit start to the UART
//   uart_tx_data [7:0]   muxed transmit byte to the UART
//   gnt_f/gnt_m          registered, mutually exclusive grants
//   tx_done_f/m          gated byte-complete strobes per requester
//   rx_do_f/m            gated byte-valid strobes per requester
//   stop_f               holds the fetcher stopped while it is not the owner
//   timeout              one-cycle pulse when a grant is revoked for inactivity
// ---------------------------------------------------------------------------
interface uart_link_arbiter_if;
    logic       req_f;
    logic       req_m;
    logic       done_f;
    logic       done_m;
    logic       tx_start_f;
    logic       tx_start_m;
    logic [7:0] tx_data_f;
    logic [7:0] tx_data_m;
    logic       uart_tx_done;
    logic       uart_rx_do;
    logic       uart_tx_start;
    logic [7:0] uart_tx_data;
    logic       gnt_f;
    logic       gnt_m;
    logic       tx_done_f;
    logic       tx_done_m;
    logic       rx_do_f;
    logic       rx_do_m;
    logic       stop_f;
    logic       timeout;

    modport slave (
        input  req_f, req_m, done_f, done_m,
        input  tx_start_f, tx_start_m, tx_data_f, tx_data_m,
        input  uart_tx_done, uart_rx_do,
        output uart_tx_start, uart_tx_data,
        output gnt_f, gnt_m,
        output tx_done_f, tx_done_m, rx_do_f, rx_do_m,
        output stop_f, timeout
    );

    modport master (
        output req_f, req_m, done_f, done_m,
        output tx_start_f, tx_start_m, tx_data_f, tx_data_m,
        output uart_tx_done, uart_rx_do,
        input  uart_tx_start, uart_tx_data,
        input  gnt_f, gnt_m,
        input  tx_done_f, tx_done_m, rx_do_f, rx_do_m,
        input  stop_f, timeout
    );
endinterface

// File: rtl/uart_link_arbiter.sv
// ---------------------------------------------------------------------------
// uart_link_arbiter
// Shares one UART TX/RX link between the instruction fetcher (F) and the
// load/store unit (M). Only one owner holds the link at a time. The owner's
// transmit controls are muxed onto the UART, and the UART strobes are routed
// only to the owner. Every release passes through a one-cycle TURN state with
// no owner. On a tie in IDLE the port that did not own the link last wins.
// last_owner resets to F, so M wins the first tie.
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high reset
//   link   : uart_link_arbiter_if.slave, all handshake and bus signals
//
// Parameters:
//   TIMEOUT_CYCLES : inactivity limit in cycles for an owned link
//   CNT_W          : inactivity counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : an inactivity counter revokes a silent grant after
//               TIMEOUT_CYCLES owned cycles and pulses timeout.
//   undefined : no counter is built, timeout stays 0, and a grant persists
//               until done_x or reset.
// ---------------------------------------------------------------------------
module uart_link_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 13
) (
    input  logic                clk,
    input  logic                reset,
    uart_link_arbiter_if.slave  link
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_F = 2'b01,
        OWN_M = 2'b10,
        TURN  = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   last_m_q, last_m_d;    // 1'b1 when M was the most recent owner
    logic   gnt_f_q, gnt_m_q;
    logic   timeout_q, timeout_d;
    logic   expire_s;              // inactivity limit reached this cycle

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             activity_s;

    assign activity_s = link.uart_tx_done | link.uart_rx_do;

    // Inactivity counter: runs only while owned. It stays zero outside
    // ownership, so every new grant starts counting from zero.
    always_comb begin
        cnt_d    = cnt_q;
        expire_s = 1'b0;
        if ((state_q == OWN_F) || (state_q == OWN_M)) begin
            if (activity_s) begin
                cnt_d = {CNT_W{1'b0}};
            end else if (cnt_q == LIMIT) begin
                cnt_d    = {CNT_W{1'b0}};
                expire_s = 1'b1;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Inactivity counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Arbitration next-state: tie-break on last owner, release on done or expiry
    always_comb begin
        state_d   = state_q;
        last_m_d  = last_m_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (link.req_f && link.req_m) begin
                    state_d = last_m_q ? OWN_F : OWN_M;
                end else if (link.req_f) begin
                    state_d = OWN_F;
                end else if (link.req_m) begin
                    state_d = OWN_M;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_F: begin
                // done_m from the non-owner and a dropped req_f are ignored
                if (link.done_f) begin
                    state_d  = TURN;
                    last_m_d = 1'b0;
                end else if (expire_s) begin
                    state_d   = TURN;
                    last_m_d  = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = OWN_F;
                end
            end
            OWN_M: begin
                if (link.done_m) begin
                    state_d  = TURN;
                    last_m_d = 1'b1;
                end else if (expire_s) begin
                    state_d   = TURN;
                    last_m_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = OWN_M;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, last-owner, grant and timeout registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_m_q  <= 1'b0;
            gnt_f_q   <= 1'b0;
            gnt_m_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_m_q  <= last_m_d;
            gnt_f_q   <= (state_d == OWN_F);
            gnt_m_q   <= (state_d == OWN_M);
            timeout_q <= timeout_d;
        end
    end

    // Link mux and strobe gating, combinational from the registered state
    always_comb begin
        link.uart_tx_start = 1'b1;
        link.uart_tx_data  = 8'h00;
        link.rx_do_f       = 1'b0;
        link.tx_done_f     = 1'b0;
        link.rx_do_m       = 1'b0;
        link.tx_done_m     = 1'b0;
        case (state_q)
            OWN_F: begin
                link.uart_tx_start = link.tx_start_f;
                link.uart_tx_data  = link.tx_data_f;
                link.rx_do_f       = link.uart_rx_do;
                link.tx_done_f     = link.uart_tx_done;
            end
            OWN_M: begin
                link.uart_tx_start = link.tx_start_m;
                link.uart_tx_data  = link.tx_data_m;
                link.rx_do_m       = link.uart_rx_do;
                link.tx_done_m     = link.uart_tx_done;
            end
            default: begin
                link.uart_tx_start = 1'b1;
                link.uart_tx_data  = 8'h00;
            end
        endcase
    end

    assign link.gnt_f   = gnt_f_q;
    assign link.gnt_m   = gnt_m_q;
    // The fetcher is held stopped in IDLE and TURN too, so it restarts cleanly on each grant
    assign link.stop_f  = (state_q != OWN_F);
    assign link.timeout = timeout_q;

endmodule

// File: tb/tb_uart_link_arbiter.sv
module tb_uart_link_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    uart_link_arbiter_if bus();

    uart_link_arbiter #(
        .TIMEOUT_CYCLES(16),
        .CNT_W(13)
    ) dut (
        .clk(clk),
        .reset(reset),
        .link(bus)
    );

    always #5 clk = ~clk;

    // advance n rising edges, then settle on the following falling edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_f        = 1'b0;
        bus.req_m        = 1'b0;
        bus.done_f       = 1'b0;
        bus.done_m       = 1'b0;
        bus.tx_start_f   = 1'b1;
        bus.tx_start_m   = 1'b1;
        bus.tx_data_f    = 8'h00;
        bus.tx_data_m    = 8'h00;
        bus.uart_tx_done = 1'b0;
        bus.uart_rx_do   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.uart_rx_do   = 1'b1;
        bus.uart_tx_done = 1'b1;
        cyc(2);
        checks++; if ({bus.gnt_f, bus.gnt_m} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {bus.gnt_f, bus.gnt_m}); end
        checks++; if (bus.uart_tx_start !== 1'b1) begin errors++; $display("FAIL reset_tx_start: got %b expected 1", bus.uart_tx_start); end
        checks++; if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.uart_tx_data); end
        checks++; if (bus.stop_f !== 1'b1) begin errors++; $display("FAIL reset_stop_f: got %b expected 1", bus.stop_f); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
        checks++; if ({bus.rx_do_f, bus.tx_done_f, bus.rx_do_m, bus.tx_done_m} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {bus.rx_do_f, bus.tx_done_f, bus.rx_do_m, bus.tx_done_m}); end
        bus.uart_rx_do   = 1'b0;
        bus.uart_tx_done = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_tie_routing_turn();
        bus.req_f = 1'b1;
        bus.req_m = 1'b1;
        cyc(1);
        checks++; if ({bus.gnt_f, bus.gnt_m} !== 2'b01) begin errors++; $display("FAIL tie_first_m: got gnt_f,gnt_m=%b expected 01", {bus.gnt_f, bus.gnt_m}); end
        checks++; if (bus.stop_f !== 1'b1) begin errors++; $display("FAIL tie_stop_f: got %b expected 1", bus.stop_f); end
        bus.tx_start_m = 1'b0; bus.tx_data_m = 8'hA5;
        bus.tx_start_f = 1'b0; bus.tx_data_f = 8'h3C;
        bus.uart_rx_do = 1'b1; bus.uart_tx_done = 1'b1;
        #1;
        checks++; if ({bus.uart_tx_start, bus.uart_tx_data} !== 9'h0A5) begin errors++; $display("FAIL mux_m: got %b/%h expected 0/a5", bus.uart_tx_start, bus.uart_tx_data); end
        checks++; if ({bus.rx_do_m, bus.tx_done_m} !== 2'b11) begin errors++; $display("FAIL strobe_m: got %b expected 11", {bus.rx_do_m, bus.tx_done_m}); end
        checks++; if ({bus.rx_do_f, bus.tx_done_f} !== 2'b00) begin errors++; $display("FAIL strobe_f_blocked: got %b expected 00", {bus.rx_do_f, bus.tx_done_f}); end
        bus.uart_rx_do = 1'b0; bus.uart_tx_done = 1'b0;
        bus.tx_start_m = 1'b1; bus.tx_start_f = 1'b1;
        // non-owner done and owner dropping its request must not release
        bus.done_f = 1'b1;
        bus.req_m  = 1'b0;
        cyc(1);
        bus.done_f = 1'b0;
        checks++; if ({bus.gnt_f, bus.gnt_m, bus.stop_f} !== 3'b011) begin errors++; $display("FAIL hold_m: got gnt_f,gnt_m,stop_f=%b expected 011", {bus.gnt_f, bus.gnt_m, bus.stop_f}); end
        bus.req_m  = 1'b1;
        bus.done_m = 1'b1;
        cyc(1);
        bus.done_m = 1'b0;
        bus.req_m  = 1'b0;
        checks++; if ({bus.gnt_f, bus.gnt_m, bus.stop_f} !== 3'b001) begin errors++; $display("FAIL turn_gnt: got gnt_f,gnt_m,stop_f=%b expected 001", {bus.gnt_f, bus.gnt_m, bus.stop_f}); end
        bus.uart_rx_do = 1'b1;
        #1;
        checks++; if ({bus.rx_do_f, bus.rx_do_m} !== 2'b00) begin errors++; $display("FAIL turn_drop_rx: got %b expected 00", {bus.rx_do_f, bus.rx_do_m}); end
        bus.uart_rx_do = 1'b0;
        cyc(1);
        checks++; if (bus.gnt_f !== 1'b0) begin errors++; $display("FAIL idle_no_gnt: got %b expected 0", bus.gnt_f); end
        cyc(1);
        checks++; if ({bus.gnt_f, bus.stop_f} !== 2'b10) begin errors++; $display("FAIL f_after_turn: got gnt_f,stop_f=%b expected 10", {bus.gnt_f, bus.stop_f}); end
    endtask

    task automatic test_reset_mid_grant();
        bus.tx_start_f = 1'b0;
        bus.tx_data_f  = 8'h3C;
        #1;
        checks++; if ({bus.uart_tx_start, bus.uart_tx_data} !== 9'h03C) begin errors++; $display("FAIL mux_f_pre_reset: got %b/%h expected 0/3c", bus.uart_tx_start, bus.uart_tx_data); end
        reset = 1'b1;
        #1;
        checks++; if (bus.gnt_f !== 1'b1) begin errors++; $display("FAIL reset_is_sync: got %b expected 1", bus.gnt_f); end
        cyc(1);
        checks++; if ({bus.gnt_f, bus.uart_tx_start, bus.stop_f} !== 3'b011) begin errors++; $display("FAIL reset_mid: got gnt_f,tx_start,stop_f=%b expected 011", {bus.gnt_f, bus.uart_tx_start, bus.stop_f}); end
        checks++; if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_mid_data: got %h expected 00", bus.uart_tx_data); end
        reset = 1'b0;
        idle_inputs();
        cyc(1);
    endtask

    task automatic test_single_f();
        bus.req_f = 1'b1;
        cyc(1);
        checks++; if ({bus.gnt_f, bus.gnt_m, bus.stop_f} !== 3'b100) begin errors++; $display("FAIL single_f_gnt: got gnt_f,gnt_m,stop_f=%b expected 100", {bus.gnt_f, bus.gnt_m, bus.stop_f}); end
        bus.tx_start_f = 1'b0;
        bus.tx_data_f  = 8'h03;
        #1;
        checks++; if ({bus.uart_tx_start, bus.uart_tx_data} !== 9'h003) begin errors++; $display("FAIL mux_f: got %b/%h expected 0/03", bus.uart_tx_start, bus.uart_tx_data); end
        bus.done_f = 1'b1;
        cyc(1);
        bus.done_f = 1'b0;
        bus.req_f  = 1'b0;
        checks++; if ({bus.gnt_f, bus.uart_tx_start, bus.stop_f} !== 3'b011) begin errors++; $display("FAIL release_f: got gnt_f,tx_start,stop_f=%b expected 011", {bus.gnt_f, bus.uart_tx_start, bus.stop_f}); end
        checks++; if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL release_f_data: got %h expected 00", bus.uart_tx_data); end
        bus.tx_start_f = 1'b1;
        cyc(1);
    endtask

    task automatic test_last_owner();
        bus.req_f = 1'b1;
        bus.req_m = 1'b1;
        cyc(1);
        checks++; if ({bus.gnt_f, bus.gnt_m} !== 2'b01) begin errors++; $display("FAIL tie_after_f: got %b expected 01", {bus.gnt_f, bus.gnt_m}); end
        bus.done_m = 1'b1;
        cyc(1);
        bus.done_m = 1'b0;
        cyc(2);
        checks++; if ({bus.gnt_f, bus.gnt_m} !== 2'b10) begin errors++; $display("FAIL tie_after_m: got %b expected 10", {bus.gnt_f, bus.gnt_m}); end
        bus.done_f = 1'b1;
        cyc(1);
        idle_inputs();
        cyc(1);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        bus.req_m = 1'b1;
        cyc(1);
        checks++; if (bus.gnt_m !== 1'b1) begin errors++; $display("FAIL to_grant: got %b expected 1", bus.gnt_m); end
        early = 0;
        for (int k = 1; k <= 15; k++) begin
            cyc(1);
            if (bus.timeout !== 1'b0 || bus.gnt_m !== 1'b1) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early: got %0d bad cycles expected 0", early); end
        cyc(1);
        checks++; if ({bus.timeout, bus.gnt_m} !== 2'b10) begin errors++; $display("FAIL to_at_16: got timeout,gnt_m=%b expected 10", {bus.timeout, bus.gnt_m}); end
        bus.req_m = 1'b0;
        cyc(1);
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b expected 0", bus.timeout); end
        bus.req_m = 1'b1;
        cyc(1);
        early = 0;
        for (int k = 1; k <= 25; k++) begin
            bus.uart_rx_do = (k == 10);
            cyc(1);
            if (bus.timeout !== 1'b0 || bus.gnt_m !== 1'b1) early++;
        end
        bus.uart_rx_do = 1'b0;
        checks++; if (early !== 0) begin errors++; $display("FAIL to_rx_early: got %0d bad cycles expected 0", early); end
        cyc(1);
        checks++; if ({bus.timeout, bus.gnt_m} !== 2'b10) begin errors++; $display("FAIL to_at_26: got timeout,gnt_m=%b expected 10", {bus.timeout, bus.gnt_m}); end
        bus.req_m = 1'b0;
        cyc(2);
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bus.req_m = 1'b1;
        cyc(1);
        checks++; if (bus.gnt_m !== 1'b1) begin errors++; $display("FAIL hold_grant: got %b expected 1", bus.gnt_m); end
        bad = 0;
        for (int k = 0; k < 10000; k++) begin
            cyc(1);
            if (bus.timeout !== 1'b0 || bus.gnt_m !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_10000: got %0d bad cycles expected 0", bad); end
        bus.done_m = 1'b1;
        cyc(1);
        bus.done_m = 1'b0;
        bus.req_m  = 1'b0;
        checks++; if (bus.gnt_m !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", bus.gnt_m); end
        cyc(1);
    endtask
`endif

    initial begin
        test_reset();
        test_tie_routing_turn();
        test_reset_mid_grant();
        test_single_f();
        test_last_owner();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
